// File: rtl/seg_scan_driver_if.sv
// Bundle between the board's data/control logic and the seven-segment scan driver.
// Latency: wires only, no storage.
// Backpressure: none; the driver always accepts Load and drives the pins continuously.
interface seg_scan_driver_if #(
  parameter int DIGITS   = 4,
  parameter int DIM_BITS = 3
);
  logic                  EN;
  logic [4*DIGITS-1:0]   Data_Hex;
  logic [DIGITS-1:0]     DP;
  logic                  Load;
  logic                  Blank_Lead;
  logic [DIM_BITS-1:0]   Bright;
  logic [DIGITS-1:0]     COM;
  logic [7:0]            SEG;
  logic                  Frame_Done;

  // Data/control source side
  modport master (
    output EN, Data_Hex, DP, Load, Blank_Lead, Bright,
    input  COM, SEG, Frame_Done
  );

  // Scan driver side
  modport slave (
    input  EN, Data_Hex, DP, Load, Blank_Lead, Bright,
    output COM, SEG, Frame_Done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit common-cathode seven-segment scanner with frame-synced loading, blanking and PWM dimming.
// Latency: COM/SEG/Frame_Done are registered, 1 cycle behind cnt/idx/display; Load reaches the display at the next frame wrap.
// Backpressure: none; Load is always accepted (last one in a frame wins), scanning free-runs while EN=1.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 5000,
  parameter int DIM_BITS = 3
) (
  input  logic               Sys_CLK,
  input  logic               Sys_RST_N,
  seg_scan_driver_if.slave   bus
);

  localparam int CW   = $clog2(DIV);
  localparam int IW   = $clog2(DIGITS);
  localparam int SLOT = DIV / (2 ** DIM_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [4*DIGITS-1:0]   pend_hex_q, pend_hex_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]   disp_hex_q, disp_hex_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     com_q, com_d;
  logic [7:0]            seg_q, seg_d;
  logic                  fd_q, fd_d;

  logic                  tick, wrap;
  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [DIGITS-1:0]     lead_zero;
  logic                  lz_run;
  logic                  blank;
  logic                  lit;
  int                    thr;

  // Glyph segments a..g (dp bit handled separately), a in the MSB.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
      4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
      4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  default: g = 7'h47;
    endcase
    return g;
  endfunction

  // Slot divider and digit index; both parked at 0 while disabled so re-enable starts on digit 0.
  always_comb begin
    tick  = bus.EN && (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!bus.EN) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Pending/display double buffer: display only swaps at a frame wrap, so a frame never mixes old and new data.
  always_comb begin
    pend_d     = pend_q;
    pend_hex_d = pend_hex_q;
    pend_dp_d  = pend_dp_q;
    disp_hex_d = disp_hex_q;
    disp_dp_d  = disp_dp_q;
    if (wrap && pend_q) begin
      disp_hex_d = pend_hex_q;
      disp_dp_d  = pend_dp_q;
      pend_d     = 1'b0;
    end
    // A Load on the wrap cycle lands in pending after the old pending moved to the display.
    if (bus.Load) begin
      pend_hex_d = bus.Data_Hex;
      pend_dp_d  = bus.DP;
      pend_d     = 1'b1;
    end
  end

  // Leading-zero flags: digit i is a leading zero when it and every digit above it are 0.
  always_comb begin
    lead_zero = '0;
    lz_run    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run       = lz_run && (disp_hex_q[4*i +: 4] == 4'h0);
      lead_zero[i] = lz_run;
    end
  end

  // Output next-state: current digit select, PWM gate, glyph with optional blanking and DP.
  always_comb begin
    cur_hex = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    thr     = (int'(bus.Bright) + 1) * SLOT;
    lit     = bus.EN && (int'(cnt_q) < thr);
    com_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_hex  = disp_hex_q[4*i +: 4];
        cur_dp   = disp_dp_q[i];
        cur_lz   = lead_zero[i];
        com_d[i] = lit;
      end
    end
    blank = bus.Blank_Lead && (idx_q != '0) && cur_lz;
    seg_d = bus.EN ? {glyph(cur_hex) & {7{~blank}}, cur_dp} : 8'h00;
    fd_d  = wrap;
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_hex_q <= '0;
      pend_dp_q  <= '0;
      disp_hex_q <= '0;
      disp_dp_q  <= '0;
      com_q      <= '0;
      seg_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_hex_q <= pend_hex_d;
      pend_dp_q  <= pend_dp_d;
      disp_hex_q <= disp_hex_d;
      disp_dp_q  <= disp_dp_d;
      com_q      <= com_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.COM        = com_q;
  assign bus.SEG        = seg_q;
  assign bus.Frame_Done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, DIV=8, DIM_BITS=2.
// Latency: samples 1 time unit after each rising edge; expectations are hand-computed glyph tables.
// Backpressure: none; frames are checked cycle by cycle against fixed expectations.
module tb_seg_scan_driver;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seg_scan_driver_if #(.DIGITS(4), .DIM_BITS(2)) bus ();

  seg_scan_driver #(.DIGITS(4), .DIV(8), .DIM_BITS(2)) dut (
    .Sys_CLK   (clk),
    .Sys_RST_N (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one 32-cycle frame starting right after a wrap (or reset release / re-enable).
  // exp_seg packs {d3,d2,d1,d0}; on = lit cycles per slot; loads are issued after step la / lb.
  task automatic scan_frame(input string name, input logic [31:0] exp_seg, input int on,
                            input int la, input logic [15:0] ha, input logic [3:0] da,
                            input int lb, input logic [15:0] hb, input logic [3:0] db);
    int d;
    int k;
    for (int s = 1; s <= 32; s++) begin
      step();
      d = (s - 1) / 8;
      k = (s - 1) % 8;
      chk($sformatf("%s.com[%0d]", name, s), 32'(bus.COM), (k < on) ? (32'd1 << d) : 32'd0);
      chk($sformatf("%s.seg[%0d]", name, s), 32'(bus.SEG), 32'(exp_seg[8*d +: 8]));
      chk($sformatf("%s.fd[%0d]", name, s), 32'(bus.Frame_Done), (s == 32) ? 32'd1 : 32'd0);
      bus.Load = 1'b0;
      if (s == la) begin
        bus.Load = 1'b1; bus.Data_Hex = ha; bus.DP = da;
      end
      if (s == lb) begin
        bus.Load = 1'b1; bus.Data_Hex = hb; bus.DP = db;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n          = 1'b0;
    bus.EN         = 1'b1;
    bus.Data_Hex   = 16'h0000;
    bus.DP         = 4'b0000;
    bus.Load       = 1'b0;
    bus.Blank_Lead = 1'b0;
    bus.Bright     = 2'd3;

    // Reset state
    step();
    step();
    chk("rst.com", 32'(bus.COM), 32'h0);
    chk("rst.seg", 32'(bus.SEG), 32'h0);
    chk("rst.fd",  32'(bus.Frame_Done), 32'h0);

    // First frame after release shows zeros; 1234 is loaded and appears from the next wrap
    rst_n = 1'b1;
    scan_frame("f_init", 32'hFCFCFCFC, 8, 1, 16'h1234, 4'h0, 0, 16'h0, 4'h0);
    // 1234 on display; ABCD loaded during digit 2 must not tear this frame
    scan_frame("f_1234", 32'h60DAF266, 8, 17, 16'hABCD, 4'h0, 0, 16'h0, 4'h0);
    // ABCD; two loads in one frame, last wins
    scan_frame("f_abcd", 32'hEE3E9C7A, 8, 3, 16'h1111, 4'h0, 10, 16'h5678, 4'h0);
    // 5678; pending 2222, then a Load exactly on the wrap tick
    scan_frame("f_5678", 32'hB6BEE0FE, 8, 5, 16'h2222, 4'h0, 31, 16'h0050, 4'b0100);
    // Wrap-tick load: previous pending (2222) displayed, 0050 waits one more frame
    scan_frame("f_2222", 32'hDADADADA, 8, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // 0050 with DP on digit 2, no blanking
    scan_frame("f_0050", 32'hFCFDB6FC, 8, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // Leading-zero blanking: digit3 dark, digit2 DP only
    bus.Blank_Lead = 1'b1;
    scan_frame("f_blank", 32'h0001B6FC, 8, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // Brightness levels
    bus.Bright = 2'd0;
    scan_frame("f_br0", 32'h0001B6FC, 2, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    bus.Bright = 2'd1;
    scan_frame("f_br1", 32'h0001B6FC, 4, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    bus.Bright = 2'd3;

    // Drop EN during digit 2
    for (int i = 0; i < 17; i++) step();
    bus.EN = 1'b0;
    step();
    chk("en0.com", 32'(bus.COM), 32'h0);
    chk("en0.seg", 32'(bus.SEG), 32'h0);
    chk("en0.fd",  32'(bus.Frame_Done), 32'h0);
    // Load while disabled is kept in pending
    bus.Load = 1'b1; bus.Data_Hex = 16'h00F0; bus.DP = 4'b0000;
    step();
    bus.Load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("en0.com_hold", 32'(bus.COM), 32'h0);
    chk("en0.seg_hold", 32'(bus.SEG), 32'h0);
    // Re-enable: scan restarts at digit 0 with the old display, then 00F0 after the wrap
    bus.EN = 1'b1;
    scan_frame("f_reen", 32'h0001B6FC, 8, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    scan_frame("f_00f0", 32'h00008EFC, 8, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    // Asynchronous reset mid-slot with a load pending
    bus.Blank_Lead = 1'b0;
    for (int i = 0; i < 12; i++) step();
    bus.Load = 1'b1; bus.Data_Hex = 16'h1234; bus.DP = 4'b1111;
    step();
    bus.Load = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.com", 32'(bus.COM), 32'h0);
    chk("arst.seg", 32'(bus.SEG), 32'h0);
    chk("arst.fd",  32'(bus.Frame_Done), 32'h0);
    step();
    rst_n = 1'b1;
    scan_frame("f_post_rst0", 32'hFCFCFCFC, 8, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    scan_frame("f_post_rst1", 32'hFCFCFCFC, 8, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
